// File: rtl/e_muldiv.sv
// e_muldiv: E-stage multiply/divide unit owning HI/LO, with a fixed-latency busy window.
module e_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] out,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic [31:0] hi_q, hi_d, lo_q, lo_d, hi_t_q, hi_t_d, lo_t_q, lo_t_d;
  logic [3:0]  count_q, count_d;
  logic        busy_q, busy_d, wr_q, wr_d;
  logic        is_mul, is_div, start, done;
  logic [63:0] prod_s, prod_u, res;
  logic [31:0] abs_a, abs_b, div_s, div_u, qm, rm, quot_s, rem_s;
  always_comb begin
    is_mul = op == 4'd1 || op == 4'd2;
    is_div = op == 4'd3 || op == 4'd4;
    start  = (is_mul || is_div) && !busy_q;
    done   = busy_q && count_q == 4'd1;
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'h0, a} * {32'h0, b};
    // Signed divide via magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
    abs_a  = a[31] ? -a : a;
    abs_b  = b[31] ? -b : b;
    div_s  = b == 32'h0 ? 32'd1 : abs_b;
    div_u  = b == 32'h0 ? 32'd1 : b;
    qm     = abs_a / div_s;
    rm     = abs_a % div_s;
    quot_s = (a[31] ^ b[31]) ? -qm : qm;
    rem_s  = a[31] ? -rm : rm;
    res    = op == 4'd1 ? prod_s :
             op == 4'd2 ? prod_u :
             op == 4'd3 ? {rem_s, quot_s} : {a % div_u, a / div_u};
  end
  always_comb begin
    hi_d    = rst ? 32'h0 : (done && wr_q) ? hi_t_q : (!busy_q && op == 4'd7) ? a : hi_q;
    lo_d    = rst ? 32'h0 : (done && wr_q) ? lo_t_q : (!busy_q && op == 4'd8) ? a : lo_q;
    hi_t_d  = rst ? 32'h0 : start ? res[63:32] : hi_t_q;
    lo_t_d  = rst ? 32'h0 : start ? res[31:0] : lo_t_q;
    wr_d    = rst ? 1'b0 : start ? !(is_div && b == 32'h0) : wr_q;
    count_d = rst ? 4'd0 : start ? (is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES)) :
              busy_q ? count_q - 4'd1 : count_q;
    busy_d  = rst ? 1'b0 : start ? 1'b1 : done ? 1'b0 : busy_q;
  end
  always_ff @(posedge clk) begin
    hi_q    <= hi_d;
    lo_q    <= lo_d;
    hi_t_q  <= hi_t_d;
    lo_t_q  <= lo_t_d;
    wr_q    <= wr_d;
    count_q <= count_d;
    busy_q  <= busy_d;
  end
  always_comb begin
    busy  = busy_q;
    stall = busy_q || start;
    out   = op == 4'd5 ? hi_q : op == 4'd6 ? lo_q : 32'h0;
    hi    = hi_q;
    lo    = lo_q;
  end
endmodule

// File: doc/e_muldiv.md
Name: e_muldiv

Overview:
- Execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Owns the architectural HI/LO registers and models multi-cycle latency with a busy counter.
- Its read port drives the E-stage MulDiv output that is carried into the E/M pipeline register alongside the ALU result.
- The hazard unit uses its stall output to hold D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu after the start cycle (legal range 1..15).
- DIV_CYCLES, 10: busy cycles for div/divu after the start cycle (legal range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- op  in  4  E-stage operation. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo. Codes 9-15 are treated as none.
- a  in  32  rs operand, already forwarded.
- b  in  32  rt operand, already forwarded.
- busy  out  1  registered; high while an operation is in flight.
- stall  out  1  combinational; busy OR start. Consumed by the hazard unit.
- out  out  32  combinational. HI when op=mfhi, LO when op=mflo, else 0.
- hi  out  32  architectural HI, for debug.
- lo  out  32  architectural LO, for debug.

Behaviour:
- Reset: rst is synchronous, active-high, on clk rising edge. It clears HI, LO, the internal result registers, count and busy to 0.
  - Reset mid-operation aborts the operation; no HI/LO update follows.
- Start:
  - start = (op in 1..4) AND NOT busy.
  - On the start cycle, the full result is computed combinationally from a and b and latched into internal hi_t/lo_t.
  - count <= MULT_CYCLES for mult ops or DIV_CYCLES for div ops; busy <= 1.
- Busy phase:
  - Each cycle with busy=1, count decrements.
  - On the cycle count==1: HI <= hi_t, LO <= lo_t, busy <= 0, count <= 0.
  - busy is therefore high for exactly N cycles, starting the cycle after start.
  - New HI/LO are visible on the first cycle busy is low again.
- Start cycle: busy=0 and stall=1.
- Ignored while busy: ops 1..4 and mthi/mtlo are ignored (no state change). The hazard unit never issues them then; the behaviour is still defined.
- mthi/mtlo: when not busy, HI (op=7) or LO (op=8) <= a at the clock edge.
- Reads (mfhi/mflo): always return the current architectural HI/LO, even while busy (pre-operation values).
- Arithmetic rules:
  - mult: signed 64-bit product of a and b; HI = [63:32], LO = [31:0].
  - multu: unsigned 64-bit product; HI = [63:32], LO = [31:0].
  - div: signed. LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Boundary cases:
  - Divide by zero (div or divu with b=0): busy runs the full DIV_CYCLES; HI/LO stay unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
  - Back-to-back: a new start is accepted on the cycle busy is low after completion, never on the completion cycle itself.

Test Plan:
- mult a=0xFFFFFFFD (-3), b=5:
  - start cycle: stall=1, busy=0.
  - busy high for 5 cycles.
  - then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - mflo during busy returns the old LO.
- multu a=0xFFFFFFFF, b=2: HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div a=-7, b=2: after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu a=7, b=2: LO=3, HI=1.
- Divide corner cases:
  - HI=0x11, LO=0x22 via mthi/mtlo, then div with b=0: 10 busy cycles, HI/LO unchanged.
  - div 0x80000000 / -1: LO=0x80000000, HI=0.
- Ignored ops while busy:
  - During a mult, issue mtlo a=0x1234 and a second multu: both ignored.
  - busy deasserts after exactly 5 cycles with the first result.
- Reset mid-operation: div started, rst asserted at busy cycle 3.
  - Next cycle: busy=0, HI=LO=0.
  - No update afterwards.
  - mfhi returns 0.
